// File: rtl/mem_access_unit.sv
// Load/store sequencer: full-word reads/writes to memory, RMW for sub-word stores, split word-crossing accesses.
// Latency accept->rsp_valid: load 2 (3 if crossing), store 3 (5 if crossing), rejected misaligned 1.
// One request in flight; req_ready is high only in IDLE, so requests wait until the previous response has issued.
module mem_access_unit #(
   parameter bit ALLOW_MISALIGNED = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_op,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic        req_datasel,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        mem_we,
   output logic        mem_AddrSrc,
   output logic [2:0]  mem_MemOp,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wd,
   input  logic [31:0] mem_rd
);

   typedef enum logic [2:0] {
      S_IDLE, S_RD0, S_RD1, S_WR0, S_WR1, S_DONE, S_ERR
   } state_t;

   state_t      state, state_next;
   logic        we_q, datasel_q;
   logic [2:0]  op_q;
   logic [31:0] addr_q, wdata_q;
   logic [31:0] w0, w1;

   // Size in bytes from the op code; unknown codes behave as a word.
   function automatic logic [2:0] size_of(input logic [2:0] op);
      case (op)
         3'b001, 3'b100: size_of = 3'd1;
         3'b010, 3'b101: size_of = 3'd2;
         default:        size_of = 3'd4;
      endcase
   endfunction

   function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] off);
      logic [2:0] sz;
      sz = size_of(op);
      is_misaligned = ((sz == 3'd2) && off[0]) || ((sz == 3'd4) && (off != 2'd0));
   endfunction

   logic [2:0]  size_q;
   logic [1:0]  off_q;
   logic        cross_q;
   logic        signed_q;
   logic [5:0]  byte_sh;
   logic [5:0]  size_bits;
   logic [63:0] mask64, data64, merged;
   logic [31:0] cur_w0, cur_w1, lo32, load_val;
   logic [31:0] base_addr;
   logic        accept;

   assign size_q    = size_of(op_q);
   assign off_q     = addr_q[1:0];
   assign cross_q   = ({2'b00, off_q} + {1'b0, size_q}) > 4'd4;
   assign signed_q  = (op_q != 3'b100) && (op_q != 3'b101);
   assign byte_sh   = {1'b0, off_q, 3'b000};
   assign size_bits = {size_q, 3'b000};
   assign base_addr = {addr_q[31:2], 2'b00};

   assign req_ready = (state == S_IDLE) && !reset;
   assign accept    = req_valid && req_ready;

   // Store merge over the two-word window: new bytes replace only their lanes.
   assign mask64 = ((64'd1 << size_bits) - 64'd1) << byte_sh;
   assign data64 = {32'd0, wdata_q} << byte_sh;
   assign merged = ({w1, w0} & ~mask64) | (data64 & mask64);

   // Words as they will be captured at this edge, so the load result is ready for DONE.
   assign cur_w0 = (state == S_RD0) ? mem_rd : w0;
   assign cur_w1 = (state == S_RD1) ? mem_rd : ((state == S_RD0) ? 32'd0 : w1);
   assign lo32   = 32'({cur_w1, cur_w0} >> byte_sh);

   // Truncate to the access size and extend.
   always_comb begin
      load_val = lo32;
      case (size_q)
         3'd1:    load_val = signed_q ? {{24{lo32[7]}}, lo32[7:0]}   : {24'd0, lo32[7:0]};
         3'd2:    load_val = signed_q ? {{16{lo32[15]}}, lo32[15:0]} : {16'd0, lo32[15:0]};
         default: load_val = lo32;
      endcase
   end

   // Next-state logic and Moore-decoded memory outputs.
   always_comb begin
      state_next  = state;
      mem_we      = 1'b0;
      mem_addr    = 32'd0;
      mem_wd      = 32'd0;
      mem_MemOp   = 3'b011;
      mem_AddrSrc = (state != S_IDLE) ? datasel_q : 1'b0;
      rsp_valid   = (state == S_DONE) || (state == S_ERR);
      case (state)
         S_IDLE: begin
            if (accept) begin
               if (!ALLOW_MISALIGNED && is_misaligned(req_op, req_addr[1:0]))
                  state_next = S_ERR;
               else
                  state_next = S_RD0;
            end
         end
         S_RD0: begin
            mem_addr = base_addr;
            if (we_q)         state_next = S_WR0;
            else if (cross_q) state_next = S_RD1;
            else              state_next = S_DONE;
         end
         S_WR0: begin
            mem_addr   = base_addr;
            mem_we     = 1'b1;
            mem_wd     = merged[31:0];
            state_next = cross_q ? S_RD1 : S_DONE;
         end
         S_RD1: begin
            mem_addr   = base_addr + 32'd4;
            state_next = we_q ? S_WR1 : S_DONE;
         end
         S_WR1: begin
            mem_addr   = base_addr + 32'd4;
            mem_we     = 1'b1;
            mem_wd     = merged[63:32];
            state_next = S_DONE;
         end
         S_DONE:  state_next = S_IDLE;
         S_ERR:   state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // State register; reset aborts any transaction in flight.
   always_ff @(posedge clk) begin
      if (reset) state <= S_IDLE;
      else       state <= state_next;
   end

   // Request latch on acceptance.
   always_ff @(posedge clk) begin
      if (reset) begin
         we_q      <= 1'b0;
         op_q      <= 3'b011;
         addr_q    <= 32'd0;
         wdata_q   <= 32'd0;
         datasel_q <= 1'b0;
      end else if (accept) begin
         we_q      <= req_we;
         op_q      <= req_op;
         addr_q    <= req_addr;
         wdata_q   <= req_wdata;
         datasel_q <= req_datasel;
      end
   end

   // Read-data capture; w1 stays zero for non-crossing accesses.
   always_ff @(posedge clk) begin
      if (reset) begin
         w0 <= 32'd0;
         w1 <= 32'd0;
      end else if (state == S_RD0) begin
         w0 <= mem_rd;
         w1 <= 32'd0;
      end else if (state == S_RD1) begin
         w1 <= mem_rd;
      end
   end

   // Response data/error, loaded on entry to DONE/ERR and held until the next response.
   always_ff @(posedge clk) begin
      if (reset) begin
         rsp_rdata <= 32'd0;
         rsp_err   <= 1'b0;
      end else if (state_next == S_DONE && state != S_DONE) begin
         rsp_rdata <= we_q ? 32'd0 : load_val;
         rsp_err   <= 1'b0;
      end else if (state_next == S_ERR) begin
         rsp_rdata <= 32'd0;
         rsp_err   <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset;
   logic        req_valid0, req_valid1, req_we, req_datasel;
   logic [2:0]  req_op;
   logic [31:0] req_addr, req_wdata;

   logic        ready0, rv0, err0, mwe0, msrc0;
   logic [2:0]  mop0;
   logic [31:0] rdata0, maddr0, mwd0, mrd0;
   logic        ready1, rv1, err1, mwe1, msrc1;
   logic [2:0]  mop1;
   logic [31:0] rdata1, maddr1, mwd1, mrd1;

   mem_access_unit #(.ALLOW_MISALIGNED(1'b1)) dut0 (
      .clk(clk), .reset(reset), .req_valid(req_valid0), .req_ready(ready0),
      .req_we(req_we), .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_datasel(req_datasel), .rsp_valid(rv0), .rsp_rdata(rdata0), .rsp_err(err0),
      .mem_we(mwe0), .mem_AddrSrc(msrc0), .mem_MemOp(mop0), .mem_addr(maddr0),
      .mem_wd(mwd0), .mem_rd(mrd0));

   mem_access_unit #(.ALLOW_MISALIGNED(1'b0)) dut1 (
      .clk(clk), .reset(reset), .req_valid(req_valid1), .req_ready(ready1),
      .req_we(req_we), .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
      .req_datasel(req_datasel), .rsp_valid(rv1), .rsp_rdata(rdata1), .rsp_err(err1),
      .mem_we(mwe1), .mem_AddrSrc(msrc1), .mem_MemOp(mop1), .mem_addr(maddr1),
      .mem_wd(mwd1), .mem_rd(mrd1));

   // Word memory, 16 words, combinational read.
   logic [31:0] mem [0:15];
   int          wr_cnt = 0;
   logic        bad_op = 1'b0;
   logic        we1_seen = 1'b0;
   assign mrd0 = mem[maddr0[5:2]];
   assign mrd1 = mem[maddr1[5:2]];

   always @(posedge clk) begin
      if (mwe0) begin
         mem[maddr0[5:2]] <= mwd0;
         wr_cnt <= wr_cnt + 1;
         if (mop0 != 3'b011) bad_op <= 1'b1;
      end
      if (mwe1) we1_seen <= 1'b1;
   end

   int n_vec = 0;
   int n_bad = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Issue one request, measure latency, sample outputs. Entered and left at #1 after posedge.
   task automatic do_req(input bit sel, input bit we, input logic [2:0] op, input logic [31:0] addr,
                         input logic [31:0] wd, input bit ds,
                         output int lat, output logic [31:0] rd, output logic er,
                         output logic [31:0] a1, output logic [31:0] a2, output logic src1,
                         output logic rdy_busy, output logic rdy_after);
      int guard = 0;
      while (!(sel ? ready1 : ready0) && guard < 20) begin
         @(posedge clk); #1; guard++;
      end
      if (guard >= 20) check("ready_timeout", 32'd0, 32'd1);
      req_we = we; req_op = op; req_addr = addr; req_wdata = wd; req_datasel = ds;
      if (sel) req_valid1 = 1'b1; else req_valid0 = 1'b1;
      @(posedge clk); #1;
      req_valid0 = 1'b0; req_valid1 = 1'b0;
      req_we = 1'($urandom); req_op = 3'($urandom); req_addr = $urandom;
      req_wdata = $urandom; req_datasel = 1'($urandom);
      lat = 1;
      a1 = sel ? maddr1 : maddr0;
      src1 = sel ? msrc1 : msrc0;
      rdy_busy = sel ? ready1 : ready0;
      a2 = 32'd0;
      while (!(sel ? rv1 : rv0) && lat < 20) begin
         @(posedge clk); #1; lat++;
         if (lat == 2) a2 = sel ? maddr1 : maddr0;
      end
      rd = sel ? rdata1 : rdata0;
      er = sel ? err1 : err0;
      @(posedge clk); #1;
      rdy_after = sel ? ready1 : ready0;
   endtask

   typedef struct {
      logic [2:0]  op;
      logic [31:0] addr;
      logic        ds;
      logic [31:0] exp_rd;
      int          exp_lat;
      logic [31:0] exp_a2;
   } ld_vec_t;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] addr;
      logic [31:0] wd;
      int          exp_lat;
      int          exp_wr;
      logic [31:0] exp_m0, exp_m1, exp_m2;
   } st_vec_t;

   ld_vec_t ld[18];
   st_vec_t st[7];

   initial begin
      int lat, w_before, rv_cnt;
      logic [31:0] rd, a1, a2;
      logic er, src1, rb, ra;

      ld[0]  = '{3'b011, 32'h0,        1'b0, 32'h80FF0011, 2, 32'h0};
      ld[1]  = '{3'b001, 32'h3,        1'b1, 32'hFFFFFF80, 2, 32'h0};
      ld[2]  = '{3'b100, 32'h3,        1'b0, 32'h00000080, 2, 32'h0};
      ld[3]  = '{3'b001, 32'h1,        1'b0, 32'h00000000, 2, 32'h0};
      ld[4]  = '{3'b010, 32'h2,        1'b0, 32'hFFFF80FF, 2, 32'h0};
      ld[5]  = '{3'b101, 32'h2,        1'b1, 32'h000080FF, 2, 32'h0};
      ld[6]  = '{3'b011, 32'h6,        1'b0, 32'h66554433, 3, 32'h8};
      ld[7]  = '{3'b011, 32'h8,        1'b0, 32'h88776655, 2, 32'h0};
      ld[8]  = '{3'b011, 32'hC,        1'b1, 32'hDEADBEEF, 2, 32'h0};
      ld[9]  = '{3'b010, 32'h7,        1'b0, 32'h00005544, 3, 32'h8};
      ld[10] = '{3'b010, 32'hB,        1'b0, 32'hFFFFEF88, 3, 32'hC};
      ld[11] = '{3'b101, 32'hB,        1'b0, 32'h0000EF88, 3, 32'hC};
      ld[12] = '{3'b010, 32'h5,        1'b0, 32'h00003322, 2, 32'h0};
      ld[13] = '{3'b111, 32'h8,        1'b0, 32'h88776655, 2, 32'h0};
      ld[14] = '{3'b001, 32'hF,        1'b0, 32'hFFFFFFDE, 2, 32'h0};
      ld[15] = '{3'b011, 32'hFFFFFFFE, 1'b0, 32'h0011CAFE, 3, 32'h0};
      ld[16] = '{3'b100, 32'h9,        1'b0, 32'h00000066, 2, 32'h0};
      ld[17] = '{3'b000, 32'h4,        1'b1, 32'h44332211, 2, 32'h0};

      st[0] = '{3'b001, 32'h5, 32'h123456AB, 3, 1, 32'h01020304, 32'h1122AB44, 32'h55667788};
      st[1] = '{3'b010, 32'h7, 32'h0000BEEF, 5, 2, 32'h01020304, 32'hEF223344, 32'h556677BE};
      st[2] = '{3'b011, 32'h0, 32'hCAFEBABE, 3, 1, 32'hCAFEBABE, 32'h11223344, 32'h55667788};
      st[3] = '{3'b010, 32'h2, 32'hFFFF5A5A, 3, 1, 32'h5A5A0304, 32'h11223344, 32'h55667788};
      st[4] = '{3'b011, 32'h5, 32'hA1B2C3D4, 5, 2, 32'h01020304, 32'hB2C3D444, 32'h556677A1};
      st[5] = '{3'b100, 32'h0, 32'h00000077, 3, 1, 32'h01020377, 32'h11223344, 32'h55667788};
      st[6] = '{3'b101, 32'h6, 32'h00009988, 3, 1, 32'h01020304, 32'h99883344, 32'h55667788};

      for (int i = 0; i < 16; i++) mem[i] = 32'd0;
      mem[0] = 32'h80FF0011; mem[1] = 32'h44332211; mem[2] = 32'h88776655;
      mem[3] = 32'hDEADBEEF; mem[15] = 32'hCAFEF00D;

      reset = 1'b1; req_valid0 = 1'b0; req_valid1 = 1'b0; req_we = 1'b0;
      req_op = 3'b011; req_addr = 32'd0; req_wdata = 32'd0; req_datasel = 1'b0;

      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      check("rst_ready", {31'd0, ready0}, 32'd0);
      check("rst_rsp_valid", {31'd0, rv0}, 32'd0);
      check("rst_rdata", rdata0, 32'd0);
      check("rst_err", {31'd0, err0}, 32'd0);
      check("rst_mem_we", {31'd0, mwe0}, 32'd0);
      check("rst_mem_addr", maddr0, 32'd0);
      check("rst_mem_wd", mwd0, 32'd0);
      check("rst_addrsrc", {31'd0, msrc0}, 32'd0);
      check("rst_memop", {29'd0, mop0}, 32'd3);
      reset = 1'b0;
      @(posedge clk); #1;
      check("ready_after_rst", {31'd0, ready0}, 32'd1);
      check("ready1_after_rst", {31'd0, ready1}, 32'd1);

      // Loads.
      for (int i = 0; i < 18; i++) begin
         w_before = wr_cnt;
         do_req(1'b0, 1'b0, ld[i].op, ld[i].addr, 32'h5A5A5A5A, ld[i].ds,
                lat, rd, er, a1, a2, src1, rb, ra);
         check($sformatf("ld%0d_rdata", i), rd, ld[i].exp_rd);
         check($sformatf("ld%0d_lat", i), lat, ld[i].exp_lat);
         check($sformatf("ld%0d_err", i), {31'd0, er}, 32'd0);
         check($sformatf("ld%0d_addr0", i), a1, {ld[i].addr[31:2], 2'b00});
         check($sformatf("ld%0d_addr1", i), a2, ld[i].exp_a2);
         check($sformatf("ld%0d_addrsrc", i), {31'd0, src1}, {31'd0, ld[i].ds});
         check($sformatf("ld%0d_ready_busy", i), {31'd0, rb}, 32'd0);
         check($sformatf("ld%0d_ready_after", i), {31'd0, ra}, 32'd1);
         check($sformatf("ld%0d_writes", i), wr_cnt - w_before, 32'd0);
      end
      check("idle_addrsrc", {31'd0, msrc0}, 32'd0);

      // Rejected misaligned accesses on the non-splitting instance.
      do_req(1'b1, 1'b0, 3'b011, 32'h2, 32'h0, 1'b0, lat, rd, er, a1, a2, src1, rb, ra);
      check("err_lw_err", {31'd0, er}, 32'd1);
      check("err_lw_rdata", rd, 32'd0);
      check("err_lw_lat", lat, 32'd1);
      check("err_held", {31'd0, err1}, 32'd1);
      do_req(1'b1, 1'b1, 3'b010, 32'h1, 32'hFFFF, 1'b0, lat, rd, er, a1, a2, src1, rb, ra);
      check("err_sh_err", {31'd0, er}, 32'd1);
      check("err_sh_lat", lat, 32'd1);
      check("err_no_mem_we", {31'd0, we1_seen}, 32'd0);
      check("err_mem_intact", mem[0], 32'h80FF0011);
      do_req(1'b1, 1'b0, 3'b001, 32'h3, 32'h0, 1'b0, lat, rd, er, a1, a2, src1, rb, ra);
      check("noerr_lb_err", {31'd0, er}, 32'd0);
      check("noerr_lb_rdata", rd, 32'hFFFFFF80);
      check("noerr_lb_lat", lat, 32'd2);

      // Stores.
      for (int i = 0; i < 7; i++) begin
         mem[0] = 32'h01020304; mem[1] = 32'h11223344; mem[2] = 32'h55667788;
         w_before = wr_cnt;
         do_req(1'b0, 1'b1, st[i].op, st[i].addr, st[i].wd, 1'b1,
                lat, rd, er, a1, a2, src1, rb, ra);
         check($sformatf("st%0d_lat", i), lat, st[i].exp_lat);
         check($sformatf("st%0d_rdata", i), rd, 32'd0);
         check($sformatf("st%0d_writes", i), wr_cnt - w_before, st[i].exp_wr);
         check($sformatf("st%0d_m0", i), mem[0], st[i].exp_m0);
         check($sformatf("st%0d_m1", i), mem[1], st[i].exp_m1);
         check($sformatf("st%0d_m2", i), mem[2], st[i].exp_m2);
      end
      check("memop_on_writes", {31'd0, bad_op}, 32'd0);

      // Reset during WR0 of a crossing store.
      mem[1] = 32'h11223344; mem[2] = 32'h55667788;
      req_we = 1'b1; req_op = 3'b010; req_addr = 32'h7; req_wdata = 32'hBEEF; req_datasel = 1'b0;
      req_valid0 = 1'b1;
      @(posedge clk); #1;
      req_valid0 = 1'b0;
      @(posedge clk); #1;
      check("abort_in_wr0", {31'd0, mwe0}, 32'd1);
      reset = 1'b1;
      @(posedge clk); #1;
      check("abort_mem_we", {31'd0, mwe0}, 32'd0);
      check("abort_rsp_valid", {31'd0, rv0}, 32'd0);
      check("abort_ready_in_rst", {31'd0, ready0}, 32'd0);
      reset = 1'b0;
      rv_cnt = 0;
      for (int c = 0; c < 4; c++) begin
         @(posedge clk); #1;
         if (rv0 || mwe0) rv_cnt++;
      end
      check("abort_ready", {31'd0, ready0}, 32'd1);
      check("abort_no_activity", rv_cnt, 32'd0);
      check("abort_wr0_kept", mem[1], 32'hEF223344);
      check("abort_word8", mem[2], 32'h55667788);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
